// File: rtl/datapath_unit_selftest.sv
// Built-in self-test stage for the ALU, extender and data memory units.
// Applies fixed vectors, counts mismatches and raises a sticky finish flag.
module datapath_unit_selftest #(
   parameter logic [31:0] DM_BASE  = 32'h0000_0000,
   parameter int          DM_WORDS = 4,
   parameter int          ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             finish,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       fail_unit,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [1:0]       alu_op,
   input  logic [31:0]      alu_y,
   input  logic             alu_zero,
   output logic [15:0]      ext_in,
   output logic [1:0]       ext_op,
   input  logic [31:0]      ext_out,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_wdata,
   output logic             dm_we,
   input  logic [31:0]      dm_rdata
);

   localparam int IDX_W = 5;

   typedef enum logic [2:0] {
      S_IDLE, S_ALU, S_EXT, S_DM_WR, S_DM_RD, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               chk_q, chk_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [1:0]         fail_q, fail_d;
   logic               finish_q, finish_d;
   logic               pass_q, pass_d;

   logic [1:0]  tbl_alu_op;
   logic [31:0] tbl_alu_a, tbl_alu_b, tbl_alu_y;
   logic        tbl_alu_zero;
   logic [1:0]  tbl_ext_op;
   logic [15:0] tbl_ext_in;
   logic [31:0] tbl_ext_out;
   logic [31:0] word_addr, word_data;
   logic        dm_we_c, mismatch;
   logic [1:0]  mismatch_unit;

   // Vector tables, indexed by the current vector number
   always_comb begin
      tbl_alu_op   = 2'b00;
      tbl_alu_a    = 32'd0;
      tbl_alu_b    = 32'd0;
      tbl_alu_y    = 32'd0;
      tbl_alu_zero = 1'b0;
      case (idx_q)
         5'd0: begin tbl_alu_op = 2'b00; tbl_alu_a = 32'd1;         tbl_alu_b = 32'd2; tbl_alu_y = 32'd3;         tbl_alu_zero = 1'b0; end
         5'd1: begin tbl_alu_op = 2'b00; tbl_alu_a = 32'hFFFF_FFFF; tbl_alu_b = 32'd1; tbl_alu_y = 32'd0;         tbl_alu_zero = 1'b1; end
         5'd2: begin tbl_alu_op = 2'b01; tbl_alu_a = 32'd5;         tbl_alu_b = 32'd7; tbl_alu_y = 32'hFFFF_FFFE; tbl_alu_zero = 1'b0; end
         5'd3: begin tbl_alu_op = 2'b01; tbl_alu_a = 32'd8;         tbl_alu_b = 32'd8; tbl_alu_y = 32'd0;         tbl_alu_zero = 1'b1; end
         default: begin
            tbl_alu_op   = 2'b10;
            tbl_alu_a    = 32'hF0F0_0000;
            tbl_alu_b    = 32'h0000_0F0F;
            tbl_alu_y    = 32'hF0F0_0F0F;
            tbl_alu_zero = 1'b0;
         end
      endcase
      tbl_ext_op  = 2'b00;
      tbl_ext_in  = 16'h8000;
      tbl_ext_out = 32'h0000_8000;
      case (idx_q[1:0])
         2'd1:    begin tbl_ext_op = 2'b01; tbl_ext_in = 16'h8000; tbl_ext_out = 32'hFFFF_8000; end
         2'd2:    begin tbl_ext_op = 2'b01; tbl_ext_in = 16'h7FFF; tbl_ext_out = 32'h0000_7FFF; end
         2'd3:    begin tbl_ext_op = 2'b10; tbl_ext_in = 16'h1234; tbl_ext_out = 32'h1234_0000; end
         default: begin tbl_ext_op = 2'b00; tbl_ext_in = 16'h8000; tbl_ext_out = 32'h0000_8000; end
      endcase
      word_addr = DM_BASE + {25'd0, idx_q, 2'b00};
      word_data = 32'hA5A5_0000 | {27'd0, idx_q};
   end

   // Sequencer: each checked vector spends one APPLY and one CHECK cycle
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      chk_d         = chk_q;
      err_d         = err_q;
      fail_d        = fail_q;
      finish_d      = finish_q;
      pass_d        = pass_q;
      alu_a         = 32'd0;
      alu_b         = 32'd0;
      alu_op        = 2'b00;
      ext_in        = 16'd0;
      ext_op        = 2'b00;
      dm_addr       = 32'd0;
      dm_wdata      = 32'd0;
      dm_we_c       = 1'b0;
      mismatch      = 1'b0;
      mismatch_unit = 2'd0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ALU;
               idx_d   = '0;
               chk_d   = 1'b0;
            end
         end
         S_ALU: begin
            alu_a  = tbl_alu_a;
            alu_b  = tbl_alu_b;
            alu_op = tbl_alu_op;
            chk_d  = ~chk_q;
            if (chk_q) begin
               mismatch      = (alu_y != tbl_alu_y) || (alu_zero != tbl_alu_zero);
               mismatch_unit = 2'd1;
               if (idx_q == 5'd4) begin
                  state_d = S_EXT;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_EXT: begin
            ext_in = tbl_ext_in;
            ext_op = tbl_ext_op;
            chk_d  = ~chk_q;
            if (chk_q) begin
               mismatch      = (ext_out != tbl_ext_out);
               mismatch_unit = 2'd2;
               if (idx_q == 5'd3) begin
                  state_d = S_DM_WR;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_DM_WR: begin
            dm_addr  = word_addr;
            dm_wdata = word_data;
            dm_we_c  = 1'b1;
            if (idx_q == IDX_W'(DM_WORDS - 1)) begin
               state_d = S_DM_RD;
               idx_d   = '0;
               chk_d   = 1'b0;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         S_DM_RD: begin
            dm_addr = word_addr;
            chk_d   = ~chk_q;
            if (chk_q) begin
               mismatch      = (dm_rdata != word_data);
               mismatch_unit = 2'd3;
               if (idx_q == IDX_W'(DM_WORDS - 1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         S_DONE: begin
            finish_d = 1'b1;
            pass_d   = (err_q == '0);
         end
         default: state_d = S_IDLE;
      endcase
      if (mismatch) begin
         if (err_q != '1) err_d = err_q + ERR_W'(1);
         if (fail_q == 2'd0) fail_d = mismatch_unit;
      end
   end

   // Reset masks the write strobe so an abandoned run cannot commit a word
   assign dm_we     = dm_we_c && !reset;
   assign finish    = finish_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_unit = fail_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         chk_q    <= 1'b0;
         err_q    <= '0;
         fail_q   <= 2'd0;
         finish_q <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         chk_q    <= chk_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
         finish_q <= finish_d;
         pass_q   <= pass_d;
      end
   end

endmodule

// File: tb/tb_datapath_unit_selftest.sv
// Bench for datapath_unit_selftest: behavioural ALU/EXT/DM models with
// injectable faults, and a scoreboard of expected run outcomes and DM writes.
module tb_datapath_unit_selftest;

   logic        clk;
   logic        reset;
   logic        start;
   logic        finish;
   logic        pass;
   logic [7:0]  err_count;
   logic [1:0]  fail_unit;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [1:0]  alu_op;
   logic        alu_zero;
   logic [15:0] ext_in;
   logic [1:0]  ext_op;
   logic [31:0] ext_out;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_we;

   logic alu_sub_fault;
   logic ext_se_fault;
   logic dm_ignore_we;

   typedef struct {
      int         err;
      logic [1:0] fail;
      logic       pass;
      int         lat;
   } result_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   result_t exp_q[$];
   wr_t     wr_q[$];
   int      checks;
   int      errors;

   logic [31:0] mem [0:15];

   datapath_unit_selftest dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .finish    (finish),
      .pass      (pass),
      .err_count (err_count),
      .fail_unit (fail_unit),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_y     (alu_y),
      .alu_zero  (alu_zero),
      .ext_in    (ext_in),
      .ext_op    (ext_op),
      .ext_out   (ext_out),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_we     (dm_we),
      .dm_rdata  (dm_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ALU model; the SUBU fault makes subtraction add instead
   always_comb begin
      case (alu_op)
         2'b00:   alu_y = alu_a + alu_b;
         2'b01:   alu_y = alu_sub_fault ? (alu_a + alu_b) : (alu_a - alu_b);
         2'b10:   alu_y = alu_a | alu_b;
         default: alu_y = 32'd0;
      endcase
      alu_zero = (alu_y == 32'd0);
   end

   // Extender model; the SE fault zero-extends instead
   always_comb begin
      case (ext_op)
         2'b00:   ext_out = {16'd0, ext_in};
         2'b01:   ext_out = ext_se_fault ? {16'd0, ext_in} : {{16{ext_in[15]}}, ext_in};
         2'b10:   ext_out = {ext_in, 16'd0};
         default: ext_out = 32'd0;
      endcase
   end

   // Data memory model, cleared on reset; the fault drops every write
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      end else if (dm_we && !dm_ignore_we) begin
         mem[dm_addr[5:2]] <= dm_wdata;
      end
   end
   assign dm_rdata = mem[dm_addr[5:2]];

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_write();
      wr_t w;
      checks++;
      if (wr_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL dm_write: unexpected write addr=%h data=%h", dm_addr, dm_wdata);
      end else begin
         w = wr_q.pop_front();
         if (dm_addr !== w.addr || dm_wdata !== w.data) begin
            errors++;
            $display("[TB] FAIL dm_write: got addr=%h data=%h expected addr=%h data=%h",
                     dm_addr, dm_wdata, w.addr, w.data);
         end
      end
   endtask

   // Launches one run, checks every DM write, then the final outcome
   task automatic run_sequence(input string name, input int exp_err, input logic [1:0] exp_fail);
      result_t r;
      int      n;
      logic    seen;
      r.err  = exp_err;
      r.fail = exp_fail;
      r.pass = (exp_err == 0);
      r.lat  = 31;
      exp_q.push_back(r);
      for (int i = 0; i < 4; i++) wr_q.push_back('{addr: 32'(4 * i), data: 32'hA5A5_0000 | 32'(i)});
      @(negedge clk);
      start = 1'b1;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (dm_we) check_write();
         if (finish) seen = 1'b1;
      end
      r = exp_q.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL %s timeout: finish=%b after %0d cycles, expected 1", name, finish, n);
      end else begin
         checks += 4;
         if (n - 1 != r.lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, n - 1, r.lat);
         end
         if (err_count !== 8'(r.err)) begin
            errors++;
            $display("[TB] FAIL %s err_count: got %0d expected %0d", name, err_count, r.err);
         end
         if (fail_unit !== r.fail) begin
            errors++;
            $display("[TB] FAIL %s fail_unit: got %0d expected %0d", name, fail_unit, r.fail);
         end
         if (pass !== r.pass) begin
            errors++;
            $display("[TB] FAIL %s pass: got %b expected %b", name, pass, r.pass);
         end
      end
      checks++;
      if (wr_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s dm_write_count: %0d writes missing, expected 0", name, wr_q.size());
      end
      wr_q.delete();
   endtask

   task automatic test_reset();
      logic bad;
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bad   = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (dm_we !== 1'b0 || finish !== 1'b0) bad = 1'b1;
      end
      checks += 4;
      if (bad) begin
         errors++;
         $display("[TB] FAIL reset_idle: finish or dm_we seen high, expected 0");
      end
      if (err_count !== 8'd0 || fail_unit !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_counts: got err=%0d unit=%0d expected 0 0", err_count, fail_unit);
      end
      if (pass !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_pass: got %b expected 0", pass);
      end
      if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 2'd0 || ext_in !== 16'd0 ||
          ext_op !== 2'd0 || dm_addr !== 32'd0 || dm_wdata !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_drives: got nonzero drive outputs, expected all 0");
      end
   endtask

   task automatic test_all_pass();
      logic bad;
      do_reset();
      run_sequence("all_pass", 0, 2'd0);
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (finish !== 1'b1 || dm_we !== 1'b0) bad = 1'b1;
      end
      start = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (finish !== 1'b1 || dm_we !== 1'b0 || alu_op !== 2'd0 || dm_addr !== 32'd0) bad = 1'b1;
      end
      start = 1'b0;
      checks += 2;
      if (bad) begin
         errors++;
         $display("[TB] FAIL done_hold: finish dropped or drives active in DONE, expected finish=1 drives 0");
      end
      if (err_count !== 8'd0 || pass !== 1'b1) begin
         errors++;
         $display("[TB] FAIL done_stable: got err=%0d pass=%b expected 0 1", err_count, pass);
      end
   endtask

   task automatic test_alu_fault();
      do_reset();
      alu_sub_fault = 1'b1;
      run_sequence("alu_fault", 2, 2'd1);
      alu_sub_fault = 1'b0;
   endtask

   task automatic test_ext_fault();
      do_reset();
      ext_se_fault = 1'b1;
      run_sequence("ext_fault", 1, 2'd2);
      ext_se_fault = 1'b0;
   endtask

   task automatic test_dm_fault();
      do_reset();
      dm_ignore_we = 1'b1;
      run_sequence("dm_fault", 4, 2'd3);
      dm_ignore_we = 1'b0;
   endtask

   task automatic test_reset_midrun();
      do_reset();
      alu_sub_fault = 1'b1;
      @(negedge clk);
      start = 1'b1;
      repeat (12) @(negedge clk);
      start = 1'b0;
      checks++;
      if (err_count !== 8'd2) begin
         errors++;
         $display("[TB] FAIL midrun_partial: got err=%0d expected 2", err_count);
      end
      do_reset();
      checks++;
      if (err_count !== 8'd0 || fail_unit !== 2'd0 || finish !== 1'b0 || alu_op !== 2'd0) begin
         errors++;
         $display("[TB] FAIL midrun_cleared: got err=%0d unit=%0d finish=%b expected 0 0 0",
                  err_count, fail_unit, finish);
      end
      alu_sub_fault = 1'b0;
      run_sequence("rerun", 0, 2'd0);
   endtask

   task automatic test_reset_during_dm_write();
      int n;
      do_reset();
      @(negedge clk);
      start = 1'b1;
      n = 0;
      while (dm_we !== 1'b1 && n < 100) begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      checks++;
      if (dm_we !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dm_wr_reach: dm_we=%b after %0d cycles, expected 1", dm_we, n);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (dm_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dm_we_reset: got %b expected 0 while reset", dm_we);
      end
      @(negedge clk);
      reset = 1'b0;
      run_sequence("after_dm_reset", 0, 2'd0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      start         = 1'b0;
      alu_sub_fault = 1'b0;
      ext_se_fault  = 1'b0;
      dm_ignore_we  = 1'b0;
      $display("[TB] starting datapath_unit_selftest bench");
      test_reset();
      test_all_pass();
      test_alu_fault();
      test_ext_fault();
      test_dm_fault();
      test_reset_midrun();
      test_reset_during_dm_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
